warp_regfile: RTL and testbench

WARP_REGFILE -- requirements
Module: warp_regfile

---
 rtl/warp_pkg.sv | 14 +
 rtl/warp_rf_bank.sv | 39 +++
 rtl/warp_regfile.sv | 146 ++++++++++++++
 tb/tb_warp_regfile.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/warp_pkg.sv
// Shared constants and types for the warp register file.
package warp_pkg;

    localparam int DEF_NUM_WARPS = 4;
    localparam int DEF_NUM_REGS  = 32;
    localparam int DEF_DATA_W    = 32;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_CLEAR,
        CLR_DONE
    } clr_state_t;

endpackage

// File: rtl/warp_rf_bank.sv
// One warp's register storage with two write ports; port A wins on a same-address write.
module warp_rf_bank
    import warp_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we_a,
    input  logic [ADDR_W-1:0]                waddr_a,
    input  logic [DATA_W-1:0]                wdata_a,
    input  logic                             we_b,
    input  logic [ADDR_W-1:0]                waddr_b,
    input  logic [DATA_W-1:0]                wdata_b,
    output logic [NUM_REGS-1:0][DATA_W-1:0]  regs
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_d, regs_q;

    always_comb begin
        regs_d = regs_q;
        if (we_b) regs_d[waddr_b] = wdata_b;
        // Port A applied last so it overrides B on a shared address.
        if (we_a) regs_d[waddr_a] = wdata_a;
        regs_d[0] = '0;
    end

    // NOTE: this storage is reset because a global clear-on-reset is part of the
    // contract; plain RAM arrays normally stay unreset so they map to memory macros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '0;
        else     regs_q <= regs_d;
    end

    assign regs = regs_q;

endmodule

// File: rtl/warp_regfile.sv
// Multi-warp register file: registered dual read with write-first bypass, two write
// ports with conflict detection, and a per-warp background clear engine.
module warp_regfile
    import warp_pkg::*;
#(
    parameter int NUM_WARPS = DEF_NUM_WARPS,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int DATA_W    = DEF_DATA_W,
    localparam int WARP_W   = $clog2(NUM_WARPS),
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [WARP_W-1:0] rd_warp,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_valid,
    input  logic              wr_en_a,
    input  logic [WARP_W-1:0] wr_warp_a,
    input  logic [ADDR_W-1:0] wr_addr_a,
    input  logic [DATA_W-1:0] wr_data_a,
    input  logic              wr_en_b,
    input  logic [WARP_W-1:0] wr_warp_b,
    input  logic [ADDR_W-1:0] wr_addr_b,
    input  logic [DATA_W-1:0] wr_data_b,
    output logic              wr_conflict,
    input  logic              clr_req,
    input  logic [WARP_W-1:0] clr_warp,
    output logic              clr_busy,
    output logic              clr_done
);

    clr_state_t        clr_state_q;
    logic [WARP_W-1:0] clr_warp_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              clr_busy_q, clr_done_q;

    logic [NUM_WARPS-1:0][NUM_REGS-1:0][DATA_W-1:0] bank_regs;

    logic a_eff, b_eff;
    logic [DATA_W-1:0] rd_data1_d, rd_data1_q, rd_data2_d, rd_data2_q;
    logic              rd_valid_d, rd_valid_q, wr_conflict_d, wr_conflict_q;

    // A write is effective unless it targets R0 or the warp being cleared.
    assign a_eff = wr_en_a && (wr_addr_a != '0) && !(clr_busy_q && (wr_warp_a == clr_warp_q));
    assign b_eff = wr_en_b && (wr_addr_b != '0) && !(clr_busy_q && (wr_warp_b == clr_warp_q));

    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_bank
        logic clr_hit;
        // Clear writes borrow port A; user writes to this warp are blocked meanwhile.
        assign clr_hit = (clr_state_q == CLR_CLEAR) && (clr_warp_q == WARP_W'(g));

        warp_rf_bank #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_bank (
            .clk     (clk),
            .rst     (rst),
            .we_a    (clr_hit || (a_eff && (wr_warp_a == WARP_W'(g)))),
            .waddr_a (clr_hit ? clr_cnt_q : wr_addr_a),
            .wdata_a (clr_hit ? '0 : wr_data_a),
            .we_b    (b_eff && (wr_warp_b == WARP_W'(g))),
            .waddr_b (wr_addr_b),
            .wdata_b (wr_data_b),
            .regs    (bank_regs[g])
        );
    end

    function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] addr);
        if (addr == '0 || (clr_busy_q && rd_warp == clr_warp_q)) return '0;
        if (a_eff && wr_warp_a == rd_warp && wr_addr_a == addr) return wr_data_a;
        if (b_eff && wr_warp_b == rd_warp && wr_addr_b == addr) return wr_data_b;
        return bank_regs[rd_warp][addr];
    endfunction

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        rd_data1_d    = rd_data1_q;
        rd_data2_d    = rd_data2_q;
        rd_valid_d    = rd_en;
        wr_conflict_d = a_eff && b_eff && (wr_warp_a == wr_warp_b) && (wr_addr_a == wr_addr_b);
        if (rd_en) begin
            rd_data1_d = read_word(rd_addr1);
            rd_data2_d = read_word(rd_addr2);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data1_q    <= '0;
            rd_data2_q    <= '0;
            rd_valid_q    <= 1'b0;
            wr_conflict_q <= 1'b0;
        end else begin
            rd_data1_q    <= rd_data1_d;
            rd_data2_q    <= rd_data2_d;
            rd_valid_q    <= rd_valid_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Clear engine: zeroes R1..R(NUM_REGS-1) of the latched warp, one per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_state_q <= CLR_IDLE;
            clr_warp_q  <= '0;
            clr_cnt_q   <= '0;
            clr_busy_q  <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            case (clr_state_q)
                CLR_IDLE: begin
                    if (clr_req) begin
                        clr_state_q <= CLR_CLEAR;
                        clr_warp_q  <= clr_warp;
                        clr_cnt_q   <= ADDR_W'(1);
                        clr_busy_q  <= 1'b1;
                    end
                end
                CLR_CLEAR: begin
                    if (clr_cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                        clr_state_q <= CLR_DONE;
                        clr_done_q  <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    end
                end
                CLR_DONE: begin
                    clr_state_q <= CLR_IDLE;
                    clr_busy_q  <= 1'b0;
                    clr_done_q  <= 1'b0;
                end
                default: clr_state_q <= CLR_IDLE;
            endcase
        end
    end

    assign rd_data1    = rd_data1_q;
    assign rd_data2    = rd_data2_q;
    assign rd_valid    = rd_valid_q;
    assign wr_conflict = wr_conflict_q;
    assign clr_busy    = clr_busy_q;
    assign clr_done    = clr_done_q;

endmodule

// File: tb/tb_warp_regfile.sv
// Directed self-checking bench for warp_regfile with default parameters.
module tb_warp_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [1:0]  rd_warp;
    logic [4:0]  rd_addr1, rd_addr2;
    logic [31:0] rd_data1, rd_data2;
    logic        rd_valid;
    logic        wr_en_a, wr_en_b;
    logic [1:0]  wr_warp_a, wr_warp_b;
    logic [4:0]  wr_addr_a, wr_addr_b;
    logic [31:0] wr_data_a, wr_data_b;
    logic        wr_conflict;
    logic        clr_req;
    logic [1:0]  clr_warp;
    logic        clr_busy, clr_done;

    int errors = 0;
    int checks = 0;

    warp_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .rd_warp    (rd_warp),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .rd_valid   (rd_valid),
        .wr_en_a    (wr_en_a),
        .wr_warp_a  (wr_warp_a),
        .wr_addr_a  (wr_addr_a),
        .wr_data_a  (wr_data_a),
        .wr_en_b    (wr_en_b),
        .wr_warp_b  (wr_warp_b),
        .wr_addr_b  (wr_addr_b),
        .wr_data_b  (wr_data_b),
        .wr_conflict(wr_conflict),
        .clr_req    (clr_req),
        .clr_warp   (clr_warp),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_en = 0; rd_warp = 0; rd_addr1 = 0; rd_addr2 = 0;
        wr_en_a = 0; wr_warp_a = 0; wr_addr_a = 0; wr_data_a = 0;
        wr_en_b = 0; wr_warp_b = 0; wr_addr_b = 0; wr_data_b = 0;
        clr_req = 0; clr_warp = 0;
    endtask

    task automatic write_a(input logic [1:0] w, input logic [4:0] a, input logic [31:0] d);
        wr_en_a = 1; wr_warp_a = w; wr_addr_a = a; wr_data_a = d;
    endtask

    task automatic write_b(input logic [1:0] w, input logic [4:0] a, input logic [31:0] d);
        wr_en_b = 1; wr_warp_b = w; wr_addr_b = a; wr_data_b = d;
    endtask

    task automatic read_req(input logic [1:0] w, input logic [4:0] a1, input logic [4:0] a2);
        rd_en = 1; rd_warp = w; rd_addr1 = a1; rd_addr2 = a2;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        #2;
        checks++;
        if ({rd_data1, rd_data2, rd_valid, wr_conflict, clr_busy, clr_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got d1=%h d2=%h v=%b c=%b b=%b d=%b, expected all 0",
                     rd_data1, rd_data2, rd_valid, wr_conflict, clr_busy, clr_done);
        end
        tick(); tick();
        rst = 0;
        // First edge after release must accept the read.
        read_req(2'd0, 5'd1, 5'd2);
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data1 !== 32'h0) begin
            errors++;
            $display("FAIL first_read_after_reset: got v=%b d1=%h, expected v=1 d1=0", rd_valid, rd_data1);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_basic_rw();
        write_a(2'd1, 5'd5, 32'h12345678);
        tick();
        idle_inputs();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_idle: got %b, expected 0", rd_valid);
        end
        read_req(2'd1, 5'd5, 5'd0);
        tick();
        idle_inputs();
        checks++;
        if (rd_data1 !== 32'h12345678 || rd_data2 !== 32'h0 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_read: got d1=%h d2=%h v=%b, expected 12345678 0 1",
                     rd_data1, rd_data2, rd_valid);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data1 !== 32'h12345678) begin
            errors++;
            $display("FAIL read_hold: got v=%b d1=%h, expected v=0 d1=12345678", rd_valid, rd_data1);
        end
    endtask

    task automatic test_bypass();
        write_a(2'd2, 5'd7, 32'hAAAA0000);
        read_req(2'd2, 5'd7, 5'd7);
        tick();
        idle_inputs();
        checks++;
        if (rd_data1 !== 32'hAAAA0000 || rd_data2 !== 32'hAAAA0000) begin
            errors++;
            $display("FAIL bypass: got d1=%h d2=%h, expected AAAA0000", rd_data1, rd_data2);
        end
    endtask

    task automatic test_dual_write();
        write_a(2'd0, 5'd3, 32'h11111111);
        write_b(2'd0, 5'd3, 32'h22222222);
        read_req(2'd0, 5'd3, 5'd3);
        tick();
        idle_inputs();
        checks++;
        if (wr_conflict !== 1'b1 || rd_data1 !== 32'h11111111) begin
            errors++;
            $display("FAIL conflict_pulse: got c=%b d1=%h, expected c=1 d1=11111111", wr_conflict, rd_data1);
        end
        read_req(2'd0, 5'd3, 5'd0);
        tick();
        idle_inputs();
        checks++;
        if (wr_conflict !== 1'b0 || rd_data1 !== 32'h11111111) begin
            errors++;
            $display("FAIL conflict_store: got c=%b d1=%h, expected c=0 d1=11111111", wr_conflict, rd_data1);
        end
        write_a(2'd0, 5'd3, 32'h55555555);
        write_b(2'd0, 5'd4, 32'h00000033);
        tick();
        idle_inputs();
        checks++;
        if (wr_conflict !== 1'b0) begin
            errors++;
            $display("FAIL no_conflict_diff: got %b, expected 0", wr_conflict);
        end
        read_req(2'd0, 5'd3, 5'd4);
        tick();
        idle_inputs();
        checks++;
        if (rd_data1 !== 32'h55555555 || rd_data2 !== 32'h00000033) begin
            errors++;
            $display("FAIL dual_store: got d1=%h d2=%h, expected 55555555 00000033", rd_data1, rd_data2);
        end
    endtask

    task automatic test_r0();
        write_a(2'd1, 5'd0, 32'hDEADBEEF);
        write_b(2'd1, 5'd0, 32'hDEADBEEF);
        read_req(2'd1, 5'd0, 5'd5);
        tick();
        idle_inputs();
        checks++;
        if (rd_data1 !== 32'h0 || rd_data2 !== 32'h12345678) begin
            errors++;
            $display("FAIL r0_bypass: got d1=%h d2=%h, expected 0 12345678", rd_data1, rd_data2);
        end
        read_req(2'd1, 5'd0, 5'd0);
        tick();
        idle_inputs();
        checks++;
        if (rd_data1 !== 32'h0 || wr_conflict !== 1'b0) begin
            errors++;
            $display("FAIL r0_write: got d1=%h c=%b, expected d1=0 c=0", rd_data1, wr_conflict);
        end
    endtask

    task automatic test_clear();
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = 0;
        int bad      = 0;
        for (int i = 1; i < 32; i++) begin
            write_a(2'd3, 5'(i), 32'(i * 100));
            tick();
        end
        idle_inputs();
        read_req(2'd3, 5'd31, 5'd2);
        tick();
        idle_inputs();
        checks++;
        if (rd_data1 !== 32'd3100 || rd_data2 !== 32'd200) begin
            errors++;
            $display("FAIL fill_warp3: got d1=%0d d2=%0d, expected 3100 200", rd_data1, rd_data2);
        end
        clr_req = 1; clr_warp = 2'd3;
        tick();
        clr_req = 0;
        for (int n = 1; n <= 40; n++) begin
            if (clr_busy) busy_cnt++;
            if (clr_done) begin done_cnt++; done_at = n; end
            idle_inputs();
            if (n == 3) begin
                write_a(2'd3, 5'd2, 32'h00000BAD);
                read_req(2'd3, 5'd31, 5'd30);
            end
            if (n == 4) begin
                checks++;
                if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
                    errors++;
                    $display("FAIL busy_read_zero: got d1=%h d2=%h, expected 0 0", rd_data1, rd_data2);
                end
                clr_req = 1; clr_warp = 2'd0;
                read_req(2'd0, 5'd3, 5'd4);
            end
            if (n == 5) begin
                checks++;
                if (rd_data1 !== 32'h55555555 || rd_data2 !== 32'h00000033) begin
                    errors++;
                    $display("FAIL other_warp_during_clear: got d1=%h d2=%h, expected 55555555 00000033",
                             rd_data1, rd_data2);
                end
            end
            tick();
        end
        checks++;
        if (busy_cnt != 32 || done_cnt != 1 || done_at != 32) begin
            errors++;
            $display("FAIL clear_timing: got busy=%0d done_cnt=%0d done_at=%0d, expected 32 1 32",
                     busy_cnt, done_cnt, done_at);
        end
        for (int r = 0; r < 32; r++) begin
            read_req(2'd3, 5'(r), 5'(r));
            tick();
            if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) bad++;
        end
        idle_inputs();
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL warp3_cleared: got %0d nonzero regs, expected 0", bad);
        end
        read_req(2'd0, 5'd3, 5'd4);
        tick();
        idle_inputs();
        checks++;
        if (rd_data1 !== 32'h55555555 || rd_data2 !== 32'h00000033) begin
            errors++;
            $display("FAIL warp0_intact: got d1=%h d2=%h, expected 55555555 00000033", rd_data1, rd_data2);
        end
    endtask

    task automatic test_reset_mid_clear();
        int busy_seen = 0;
        int done_seen = 0;
        int bad       = 0;
        int n         = 0;
        clr_req = 1; clr_warp = 2'd1;
        read_req(2'd2, 5'd7, 5'd7);
        tick();
        clr_req = 0;
        repeat (9) tick();
        checks++;
        if (clr_busy !== 1'b1 || rd_valid !== 1'b1 || rd_data1 !== 32'hAAAA0000) begin
            errors++;
            $display("FAIL pre_reset_state: got b=%b v=%b d1=%h, expected 1 1 AAAA0000",
                     clr_busy, rd_valid, rd_data1);
        end
        rst = 1;
        #1;
        checks++;
        if ({rd_data1, rd_data2, rd_valid, wr_conflict, clr_busy, clr_done} !== '0) begin
            errors++;
            $display("FAIL async_reset: got d1=%h d2=%h v=%b c=%b b=%b d=%b, expected all 0",
                     rd_data1, rd_data2, rd_valid, wr_conflict, clr_busy, clr_done);
        end
        idle_inputs();
        tick(); tick();
        rst = 0;
        repeat (40) begin
            tick();
            if (clr_busy) busy_seen++;
            if (clr_done) done_seen++;
        end
        checks++;
        if (busy_seen != 0 || done_seen != 0) begin
            errors++;
            $display("FAIL abandoned_clear: got busy=%0d done=%0d, expected 0 0", busy_seen, done_seen);
        end
        for (int w = 0; w < 4; w++) begin
            for (int r = 0; r < 32; r++) begin
                read_req(2'(w), 5'(r), 5'(r));
                tick();
                if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) bad++;
            end
        end
        idle_inputs();
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL banks_zero_after_reset: got %0d nonzero reads, expected 0", bad);
        end
        clr_req = 1; clr_warp = 2'd0;
        tick();
        clr_req = 0;
        checks++;
        if (clr_busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_after_reset: got busy=%b, expected 1", clr_busy);
        end
        while (!clr_done && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (clr_done !== 1'b1) begin
            errors++;
            $display("FAIL clear_after_reset_done: no clr_done within 40 cycles");
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_bypass();
        test_dual_write();
        test_r0();
        test_clear();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
